// File: rtl/counter_event_monitor.sv
// Watches an upstream up/down counter: wrap pulses with a saturating wrap tally, an arm/match FSM, shadowed compare.
// Pulses register one edge after the stepped value appears; define COUNTER_EVENT_MONITOR_PWM_EN for the PWM comparator.
module counter_event_monitor #(
  parameter int N      = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      count_in,
  input  logic              cnt_en,
  input  logic              cnt_load,
  input  logic              cnt_up_down,
  input  logic [N-1:0]      cmp_value,
  input  logic              cmp_wr,
  input  logic              arm,
  input  logic              disarm,
  input  logic              periodic,
  input  logic              clr_wrap,
  output logic              match_pulse,
  output logic              wrap_up_pulse,
  output logic              wrap_dn_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              wrap_sat,
  output logic [1:0]        state,
  output logic              pwm_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              en_q, load_q, up_q;
  logic [N-1:0]      cmp_q, cmp_d;
  logic [N-1:0]      shadow_q, shadow_d;
  logic              pend_q, pend_d;
  logic [WRAP_W-1:0] wcnt_q, wcnt_d;
  logic              wsat_q, wsat_d;
  logic              match_q, match_d;
  logic              wup_q, wdn_q;

  logic step, wrap_up, wrap_dn, wrap_evt, match;

  // Control copies are delayed one cycle so they line up with the count they produced.
  assign step     = en_q & ~load_q;
  assign wrap_up  = step & up_q & (count_in == '0);
  assign wrap_dn  = step & ~up_q & (count_in == '1);
  assign wrap_evt = wrap_up | wrap_dn;
  assign match    = (state_q == ARMED) & step & (count_in == cmp_q);

  always_comb begin
    state_d = state_q;
    match_d = match & ~disarm;
    if (disarm) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm) state_d = ARMED;
        ARMED:   if (match && !periodic) state_d = FIRED;
        FIRED:   if (arm) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // A write while ARMED waits in the shadow until a wrap, so a lap never sees two compare values.
  always_comb begin
    cmp_d    = cmp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (wrap_evt && pend_q) begin
      cmp_d  = shadow_q;
      pend_d = 1'b0;
    end
    if (cmp_wr) begin
      if (state_q == ARMED) begin
        shadow_d = cmp_value;
        pend_d   = 1'b1;
      end else begin
        cmp_d  = cmp_value;
        pend_d = 1'b0;
      end
    end
  end

  always_comb begin
    wcnt_d = wcnt_q;
    wsat_d = wsat_q;
    if (clr_wrap) begin
      wcnt_d = '0;
      wsat_d = 1'b0;
    end else begin
      if (wrap_evt && (wcnt_q != '1)) wcnt_d = wcnt_q + WRAP_W'(1);
      wsat_d = wsat_q | (wcnt_d == '1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      load_q   <= 1'b0;
      up_q     <= 1'b0;
      cmp_q    <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      wcnt_q   <= '0;
      wsat_q   <= 1'b0;
      match_q  <= 1'b0;
      wup_q    <= 1'b0;
      wdn_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= cnt_en;
      load_q   <= cnt_load;
      up_q     <= cnt_up_down;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      wcnt_q   <= wcnt_d;
      wsat_q   <= wsat_d;
      match_q  <= match_d;
      wup_q    <= wrap_up;
      wdn_q    <= wrap_dn;
    end
  end

`ifdef COUNTER_EVENT_MONITOR_PWM_EN
  logic pwm_q;

  always_ff @(posedge clk) begin
    if (reset) pwm_q <= 1'b0;
    else       pwm_q <= (count_in < cmp_q);
  end

  assign pwm_out = pwm_q;
`else
  assign pwm_out = 1'b0;
`endif

  assign match_pulse   = match_q;
  assign wrap_up_pulse = wup_q;
  assign wrap_dn_pulse = wdn_q;
  assign wrap_count    = wcnt_q;
  assign wrap_sat      = wsat_q;
  assign state         = state_q;

endmodule

// File: tb/tb_counter_event_monitor.sv
// Directed bench for counter_event_monitor (N=4, WRAP_W=2) with a behavioural upstream counter.
module tb_counter_event_monitor;

  logic       clk = 1'b0;
  logic       reset, cnt_en, cnt_load, cnt_up_down, cmp_wr, arm, disarm, periodic, clr_wrap;
  logic [3:0] count, load_val, cmp_value;
  logic       match_pulse, wrap_up_pulse, wrap_dn_pulse, wrap_sat, pwm_out;
  logic [1:0] wrap_count;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int n_up = 0;
  int n_dn = 0;
  int snap, nm, m1, m2;
  logic exp_pwm;

  counter_event_monitor #(.N(4), .WRAP_W(2)) dut (
    .clk(clk), .reset(reset), .count_in(count),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_up_down(cnt_up_down),
    .cmp_value(cmp_value), .cmp_wr(cmp_wr), .arm(arm), .disarm(disarm),
    .periodic(periodic), .clr_wrap(clr_wrap),
    .match_pulse(match_pulse), .wrap_up_pulse(wrap_up_pulse), .wrap_dn_pulse(wrap_dn_pulse),
    .wrap_count(wrap_count), .wrap_sat(wrap_sat), .state(state), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  // Upstream counter the monitor is watching.
  always @(posedge clk) begin
    if (reset)         count <= 4'd0;
    else if (cnt_load) count <= load_val;
    else if (cnt_en)   count <= cnt_up_down ? count + 4'd1 : count - 4'd1;
  end

  always @(posedge clk) begin
    if (wrap_up_pulse) n_up <= n_up + 1;
    if (wrap_dn_pulse) n_dn <= n_dn + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Load the value just before the wrap, step once, then one idle cycle; the pulse is visible on return.
  task automatic do_wrap(input logic up, input logic clr);
    cnt_load = 1'b1; load_val = up ? 4'd15 : 4'd0; cnt_en = 1'b0;
    tick();
    cnt_load = 1'b0; cnt_en = 1'b1; cnt_up_down = up;
    tick();
    cnt_en = 1'b0; clr_wrap = clr;
    tick();
    clr_wrap = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cnt_en = 0; cnt_load = 0; cnt_up_down = 0; load_val = 0;
    cmp_value = 0; cmp_wr = 0; arm = 0; disarm = 0; periodic = 0; clr_wrap = 0;
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_wcnt", wrap_count, 0);
    check("rst_sat", wrap_sat, 0);
    check("rst_match", match_pulse, 0);
    check("rst_up", wrap_up_pulse, 0);
    check("rst_pwm", pwm_out, 0);
    reset = 1'b0;
    tick();

    // Count up from 14 through the 15->0 wrap.
    cnt_load = 1; load_val = 4'd14;
    tick();
    cnt_load = 0; cnt_en = 1; cnt_up_down = 1;
    tick();
    tick();
    cnt_en = 0;
    check("up_early", wrap_up_pulse, 0);
    tick();
    check("up_pulse", wrap_up_pulse, 1);
    check("up_wcnt1", wrap_count, 1);
    check("up_dn_quiet", wrap_dn_pulse, 0);
    tick();
    check("up_one_cycle", wrap_up_pulse, 0);

    // Loads to 15 and to 0 are not wraps.
    snap = n_up + n_dn;
    cnt_load = 1; load_val = 4'd15;
    tick();
    load_val = 4'd0;
    tick();
    cnt_load = 0;
    tick(); tick();
    check("load_no_pulse", n_up + n_dn, snap);
    check("load_wcnt", wrap_count, 1);

    // Saturation at WRAP_W=2, then clear racing a fifth wrap.
    do_wrap(1'b0, 1'b0);
    check("dn_pulse", wrap_dn_pulse, 1);
    check("wcnt2", wrap_count, 2);
    do_wrap(1'b1, 1'b0);
    check("wcnt3", wrap_count, 3);
    do_wrap(1'b0, 1'b0);
    check("wcnt_sat", wrap_count, 3);
    check("sat_set", wrap_sat, 1);
    do_wrap(1'b1, 1'b1);
    check("clr_pulse", wrap_up_pulse, 1);
    check("clr_wcnt", wrap_count, 0);
    check("clr_sat", wrap_sat, 0);

    // One-shot match at 9, two laps.
    cmp_value = 4'd9; cmp_wr = 1;
    tick();
    cmp_wr = 0; arm = 1; periodic = 0;
    tick();
    arm = 0;
    check("armed", state, 1);
    cnt_load = 1; load_val = 4'd0;
    tick();
    cnt_load = 0; cnt_en = 1; cnt_up_down = 1;
    nm = 0; m1 = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (match_pulse) begin
        nm++;
        if (m1 == 0) m1 = i;
      end
    end
    cnt_en = 0;
    tick();
    check("oneshot_count", nm, 1);
    check("oneshot_at", m1, 10);
    check("fired", state, 2);
    check("lap_wcnt", wrap_count, 2);

    // Periodic re-arm with a shadowed compare write.
    periodic = 1; arm = 1;
    tick();
    arm = 0;
    check("rearmed", state, 1);
    cmp_value = 4'd3; cmp_wr = 1;
    tick();
    cmp_wr = 0; cnt_en = 1;
    nm = 0; m1 = 0; m2 = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (match_pulse) begin
        nm++;
        if (m1 == 0) m1 = i;
        else if (m2 == 0) m2 = i;
      end
    end
    cnt_en = 0;
    check("periodic_count", nm, 2);
    check("periodic_old_cmp", m1, 10);
    check("periodic_new_cmp", m2, 20);
    check("still_armed", state, 1);

    // Disarm priority.
    disarm = 1;
    tick();
    disarm = 0;
    check("disarm", state, 0);
    arm = 1; disarm = 1;
    tick();
    arm = 0; disarm = 0;
    check("arm_disarm", state, 0);
    periodic = 0; cmp_value = 4'd9; cmp_wr = 1;
    tick();
    cmp_wr = 0; arm = 1;
    tick();
    arm = 0;
    cnt_load = 1; load_val = 4'd8;
    tick();
    cnt_load = 0; cnt_en = 1;
    tick();
    cnt_en = 0; disarm = 1;
    tick();
    disarm = 0;
    check("disarm_match_pulse", match_pulse, 0);
    check("disarm_match_state", state, 0);

    // Reset while ARMED on a matching count.
    arm = 1;
    tick();
    arm = 0;
    cnt_load = 1; load_val = 4'd8;
    tick();
    cnt_load = 0; cnt_en = 1;
    tick();
    check("pre_rst_wcnt", wrap_count, 3);
    check("pre_rst_sat", wrap_sat, 1);
    cnt_en = 0; reset = 1;
    tick();
    check("mid_rst_state", state, 0);
    check("mid_rst_match", match_pulse, 0);
    check("mid_rst_wcnt", wrap_count, 0);
    check("mid_rst_sat", wrap_sat, 0);
    check("mid_rst_up", wrap_up_pulse, 0);
    check("mid_rst_dn", wrap_dn_pulse, 0);
    check("mid_rst_pwm", pwm_out, 0);
    reset = 0;
    tick();

    // PWM sweep with compare 4.
    cmp_value = 4'd4; cmp_wr = 1;
    tick();
    cmp_wr = 0; cnt_load = 1; load_val = 4'd0;
    tick();
    cnt_load = 0; cnt_en = 1; cnt_up_down = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
`ifdef COUNTER_EVENT_MONITOR_PWM_EN
      exp_pwm = (i < 4);
`else
      exp_pwm = 1'b0;
`endif
      check($sformatf("pwm_%0d", i), pwm_out, exp_pwm);
    end
    cnt_en = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
